bcd_conversion_scheduler: RTL and testbench
===========================================

# bcd_conversion_scheduler

Shares one serial double-dabble binary-to-BCD engine among `NumChannels` requesters (display channels, measurement readouts) using round-robin arbitration. Each requester hands over a binary value with a level request and receives a registered BCD result plus a one-cycle valid pulse. It sits between measurement/counter logic and the seven-segment display drivers, replacing per-channel free-running converters.

## Interface
- `BitWidth`, 17, width of each binary input.
- `BCDDigits`, 6, BCD digits per result. Elaboration check: 2^BitWidth−1 < 10^BCDDigits.
- `NumChannels`, 4, number of requesters, 2..16.
- `Clk`  in  1  main clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NumChannels  per-channel conversion request, level.
- `BinaryIn`  in  NumChannels*BitWidth  per-channel value; channel k at bits [k*BitWidth +: BitWidth].
- `ack`  out  NumChannels  one-cycle pulse: channel's value captured.
- `BCDOut`  out  NumChannels*BCDDigits*4  per-channel result register; channel k at [k*BCDDigits*4 +: BCDDigits*4], digit 0 = LSD.
- `bcd_valid`  out  NumChannels  one-cycle pulse: channel's `BCDOut` just updated.
- `busy`  out  1  high while a conversion is in progress (SHIFT or DONE).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if any `req` high, grant first requesting channel searching upward (wrapping) from `last_grant+1`; capture its `BinaryIn`, clear BCD accumulator, load bit counter = BitWidth, record channel, go SHIFT. No request: stay IDLE.
- SHIFT: each cycle, every digit > 4 gets +3, then accumulator shifts left by one taking the binary MSB; binary shifts left; counter decrements. After BitWidth SHIFT cycles go DONE.
- DONE: write accumulator to granted channel's `BCDOut` slice, pulse its `bcd_valid`, update `last_grant`, return IDLE.
- Requester rules: hold `req` and keep `BinaryIn` stable until `ack`; drop `req` the cycle after `ack` unless another conversion is wanted (a `req` still high in the next IDLE is a new request). Dropping `req` before grant cancels with no side effects.
- Other channels' `BCDOut` unchanged during a conversion.
- Digit adjust: 4-bit, never carries between digits; result exact for all legal inputs.
- Reset (any cycle, including mid-SHIFT): state IDLE, `last_grant` = NumChannels−1 (channel 0 first), `ack`, `bcd_valid`, `busy` = 0, all `BCDOut` = 0; in-flight conversion discarded, no `bcd_valid`.

## Timing
- All outputs registered.
- `req` seen in IDLE at edge t → `ack` high cycle t+1 only; `busy` high t+1 .. t+BitWidth+1.
- SHIFT occupies cycles t+1 .. t+BitWidth; DONE at t+BitWidth+1.
- `BCDOut` slice and `bcd_valid` visible from cycle t+BitWidth+2; `bcd_valid` one cycle.
- Next grant earliest at edge t+BitWidth+2 (IDLE); throughput one conversion per BitWidth+2 cycles (19 at defaults).
- Worst-case wait for continuously requesting channel: (NumChannels−1)*(BitWidth+2) cycles before grant.
- `ack` and `bcd_valid` never both high for the same channel in one cycle.

## Structure
- Shared package: state encoding, `clog2` function (counter and channel index widths), result-width constant BCDDigits*4.
- One sub-module `bcd_shift_core`: start/load input, binary in, BCD out, `done` strobe; holds accumulator, binary shift register, counter. Scheduler keeps arbiter, `last_grant`, output registers.

## Test plan
- Ch0 requests 12345 alone → `ack[0]` at t+1, `BCDOut` ch0 = 0x012345 with single `bcd_valid[0]` at t+19; other slices 0.
- Ch1 requests 131071 (max) → 0x131071; ch2 requests 0 → 0x000000 with valid pulse.
- All four request simultaneously (1, 22, 333, 4444) → grants 0,1,2,3, acks 19 cycles apart, results 0x000001, 0x000022, 0x000333, 0x004444.
- After that, ch0 and ch2 request together → ch0 first (wrap after 3), then ch2; ch2 re-requests while ch0 converts → served directly after.
- `reset` low mid-SHIFT on ch3 → no `bcd_valid`, all `BCDOut` 0, `busy` 0; after release, ch0 wins tie with ch3.
- Ch1 raises then drops `req` before grant while ch0 converts → no `ack[1]`, no `bcd_valid[1]`, `BCDOut` ch1 unchanged.

Source files
------------

// File: rtl/bcd_conversion_scheduler_pkg.sv
// Shared types and constant helpers for the round-robin BCD conversion scheduler.
package bcd_conversion_scheduler_pkg;

  localparam int unsigned DefBitWidth    = 17;
  localparam int unsigned DefBCDDigits   = 6;
  localparam int unsigned DefNumChannels = 4;
  localparam int unsigned DigitW         = 4;
  localparam int unsigned ResultW        = DefBCDDigits * DigitW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Minimum of one bit so single-value ranges still get a usable vector
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // True when every BitWidth-bit value fits in the given number of BCD digits
  function automatic bit bcd_fits(input int unsigned bw, input int unsigned digits);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) p = p * 64'd10;
    return ((64'd1 << bw) - 64'd1) < p;
  endfunction

endpackage

// File: rtl/bcd_shift_core.sv
// Serial double-dabble engine: one bit per cycle, BitWidth cycles per conversion.
module bcd_shift_core
  import bcd_conversion_scheduler_pkg::*;
#(
  parameter int unsigned BitWidth  = DefBitWidth,
  parameter int unsigned BCDDigits = DefBCDDigits
) (
  input  logic                          Clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BitWidth-1:0]           bin_in,
  output logic [BCDDigits*DigitW-1:0]   bcd,
  output logic                          done_c
);

  localparam int unsigned ResW = BCDDigits * DigitW;
  localparam int unsigned CntW = clog2(BitWidth + 1);

  logic [ResW-1:0]     acc_q;
  logic [ResW-1:0]     adj_c;
  logic [BitWidth-1:0] bin_q;
  logic [CntW-1:0]     cnt_q;

  // Per-digit add-3; digits are 4-bit and never carry into a neighbour
  always_comb begin
    adj_c = acc_q;
    for (int unsigned d = 0; d < BCDDigits; d++) begin
      if (acc_q[d*DigitW +: DigitW] > DigitW'(4))
        adj_c[d*DigitW +: DigitW] = acc_q[d*DigitW +: DigitW] + DigitW'(3);
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      acc_q <= '0;
      bin_q <= bin_in;
      cnt_q <= CntW'(BitWidth);
    end else if (cnt_q != '0) begin
      acc_q <= {adj_c[ResW-2:0], bin_q[BitWidth-1]};
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign bcd    = acc_q;
  assign done_c = (cnt_q == CntW'(1));

endmodule

// File: rtl/bcd_conversion_scheduler.sv
// Round-robin arbiter sharing one serial BCD engine among NumChannels requesters.
module bcd_conversion_scheduler
  import bcd_conversion_scheduler_pkg::*;
#(
  parameter int unsigned BitWidth    = DefBitWidth,
  parameter int unsigned BCDDigits   = DefBCDDigits,
  parameter int unsigned NumChannels = DefNumChannels
) (
  input  logic                                    Clk,
  input  logic                                    reset,
  input  logic [NumChannels-1:0]                  req,
  input  logic [NumChannels*BitWidth-1:0]         BinaryIn,
  output logic [NumChannels-1:0]                  ack,
  output logic [NumChannels*BCDDigits*DigitW-1:0] BCDOut,
  output logic [NumChannels-1:0]                  bcd_valid,
  output logic                                    busy
);

  localparam int unsigned ResW = BCDDigits * DigitW;
  localparam int unsigned ChW  = clog2(NumChannels);

  if (!bcd_fits(BitWidth, BCDDigits) || NumChannels < 2 || NumChannels > 16) begin : g_param_check
    $error("bcd_conversion_scheduler: illegal BitWidth/BCDDigits/NumChannels combination");
  end

  state_e          state_q;
  logic [ChW-1:0]  last_grant_q;
  logic [ChW-1:0]  grant_q;
  logic [ChW-1:0]  pick_c;
  logic            pick_vld_c;
  logic            start_c;
  logic            core_done_c;
  logic [ResW-1:0] core_bcd;
  logic [BitWidth-1:0] bin_arr [NumChannels];
  logic [ResW-1:0]     bcd_q   [NumChannels];

  for (genvar k = 0; k < NumChannels; k++) begin : g_ch
    assign bin_arr[k]                = BinaryIn[k*BitWidth +: BitWidth];
    assign BCDOut[k*ResW +: ResW]    = bcd_q[k];
  end

  // First requester searching upward from last_grant+1, wrapping
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_c     = '0;
    pick_vld_c = 1'b0;
    for (int unsigned i = 1; i <= NumChannels; i++) begin
      idx = (32'(last_grant_q) + i) % NumChannels;
      if (!pick_vld_c && req[ChW'(idx)]) begin
        pick_vld_c = 1'b1;
        pick_c     = ChW'(idx);
      end
    end
  end

  assign start_c = (state_q == ST_IDLE) && pick_vld_c;

  bcd_shift_core #(
    .BitWidth  (BitWidth),
    .BCDDigits (BCDDigits)
  ) u_core (
    .Clk    (Clk),
    .reset  (reset),
    .start  (start_c),
    .bin_in (bin_arr[pick_c]),
    .bcd    (core_bcd),
    .done_c (core_done_c)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ChW'(NumChannels - 1);
      grant_q      <= '0;
      ack          <= '0;
      bcd_valid    <= '0;
      busy         <= 1'b0;
      for (int unsigned k = 0; k < NumChannels; k++) bcd_q[k] <= '0;
    end else begin
      ack       <= '0;
      bcd_valid <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld_c) begin
            grant_q     <= pick_c;
            ack[pick_c] <= 1'b1;
            busy        <= 1'b1;
            state_q     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (core_done_c) state_q <= ST_DONE;
        end
        ST_DONE: begin
          bcd_q[grant_q]     <= core_bcd;
          bcd_valid[grant_q] <= 1'b1;
          last_grant_q       <= grant_q;
          busy               <= 1'b0;
          state_q            <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conversion_scheduler.sv
// Directed plus randomized bench: round-robin order and BCD values come from an arithmetic model.
module tb_bcd_conversion_scheduler;

  localparam int unsigned BW = 17;
  localparam int unsigned DG = 6;
  localparam int unsigned NC = 4;
  localparam int unsigned RW = DG * 4;
  localparam int unsigned MaxVal = (1 << BW) - 1;

  logic              Clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     req;
  logic [NC*BW-1:0]  bin_flat;
  logic [NC-1:0]     ack;
  logic [NC*RW-1:0]  BCDOut;
  logic [NC-1:0]     bcd_valid;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int unsigned     vals    [NC];
  logic [RW-1:0]   exp_bcd [NC];
  int unsigned     lg;

  bcd_conversion_scheduler #(
    .BitWidth    (BW),
    .BCDDigits   (DG),
    .NumChannels (NC)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .req       (req),
    .BinaryIn  (bin_flat),
    .ack       (ack),
    .BCDOut    (BCDOut),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [NC*RW-1:0] obs, input logic [NC*RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] to_bcd(input int unsigned v);
    logic [RW-1:0] r;
    int unsigned   x;
    r = '0;
    x = v;
    for (int unsigned d = 0; d < DG; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [NC*RW-1:0] exp_flat();
    logic [NC*RW-1:0] f;
    f = '0;
    for (int unsigned c = 0; c < NC; c++) f[c*RW +: RW] = exp_bcd[c];
    return f;
  endfunction

  function automatic int unsigned pick(input logic [NC-1:0] m, input int unsigned last);
    for (int unsigned i = 1; i <= NC; i++) begin
      if (m[(last + i) % NC]) return (last + i) % NC;
    end
    return 0;
  endfunction

  function automatic logic [NC-1:0] onehot(input int unsigned c);
    return NC'(1) << c;
  endfunction

  task automatic set_val(input int unsigned ch, input int unsigned v);
    vals[ch] = v;
    bin_flat[ch*BW +: BW] = BW'(v);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    reset = 1'b0;
    req   = '0;
    #1;
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_ack", 96'(ack), 96'(0));
    check("rst_valid", 96'(bcd_valid), 96'(0));
    check("rst_bcdout", BCDOut, 96'(0));
    lg = NC - 1;
    for (int unsigned c = 0; c < NC; c++) exp_bcd[c] = '0;
    @(negedge Clk);
    reset = 1'b1;
  endtask

  // Raise mask now and late in the first ack cycle; follow every grant to its result
  task automatic run_batch(input logic [NC-1:0] mask, input logic [NC-1:0] late);
    logic [NC-1:0]    pending;
    logic [NC*RW-1:0] prev;
    int unsigned      g;
    bit               first;
    pending = mask;
    first   = 1'b1;
    req     = req | mask;
    while (pending != '0) begin
      g = pick(pending, lg);
      @(negedge Clk);
      check("ack", 96'(ack), 96'(onehot(g)));
      check("busy_start", 96'(busy), 96'(1));
      req[g]     = 1'b0;
      pending[g] = 1'b0;
      if (first) begin
        req     = req | late;
        pending = pending | late;
        first   = 1'b0;
      end
      lg         = g;
      prev       = exp_flat();
      exp_bcd[g] = to_bcd(vals[g]);
      repeat (17) @(negedge Clk);
      check("valid_early", 96'(bcd_valid), 96'(0));
      check("bcdout_hold", BCDOut, prev);
      check("busy_mid", 96'(busy), 96'(1));
      @(negedge Clk);
      check("bcd_valid", 96'(bcd_valid), 96'(onehot(g)));
      check("bcdout", BCDOut, exp_flat());
      check("busy_end", 96'(busy), 96'(0));
      check("ack_quiet", 96'(ack), 96'(0));
    end
  endtask

  initial begin
    logic [NC-1:0] m;
    logic [NC-1:0] lt;
    reset    = 1'b0;
    req      = '0;
    bin_flat = '0;
    for (int unsigned c = 0; c < NC; c++) vals[c] = 0;
    do_reset();

    set_val(0, 12345);
    run_batch(4'b0001, 4'b0000);
    check("ch0_12345", 96'(exp_bcd[0]), 96'(24'h012345));
    set_val(1, MaxVal);
    run_batch(4'b0010, 4'b0000);
    set_val(2, 0);
    run_batch(4'b0100, 4'b0000);

    do_reset();
    set_val(0, 1);
    set_val(1, 22);
    set_val(2, 333);
    set_val(3, 4444);
    run_batch(4'b1111, 4'b0000);

    set_val(0, 9876);
    set_val(2, 54321);
    run_batch(4'b0101, 4'b0000);
    set_val(0, 100000);
    set_val(2, 77);
    run_batch(4'b0001, 4'b0100);

    // Reset in the middle of a conversion on ch3
    set_val(3, 99999);
    req[3] = 1'b1;
    @(negedge Clk);
    check("ack_ch3", 96'(ack), 96'(4'b1000));
    req[3] = 1'b0;
    repeat (5) @(negedge Clk);
    do_reset();
    set_val(0, 4321);
    set_val(3, 8765);
    run_batch(4'b1001, 4'b0000);

    // Ch1 requests briefly while ch0 converts, then withdraws
    set_val(0, 55555);
    set_val(1, 31337);
    req[0] = 1'b1;
    @(negedge Clk);
    check("cancel_ack0", 96'(ack), 96'(4'b0001));
    req[0] = 1'b0;
    lg = 0;
    exp_bcd[0] = to_bcd(vals[0]);
    @(negedge Clk);
    req[1] = 1'b1;
    repeat (3) @(negedge Clk);
    req[1] = 1'b0;
    repeat (13) @(negedge Clk);
    check("cancel_valid_early", 96'(bcd_valid), 96'(0));
    @(negedge Clk);
    check("cancel_valid", 96'(bcd_valid), 96'(4'b0001));
    check("cancel_bcdout", BCDOut, exp_flat());
    @(negedge Clk);
    check("cancel_no_ack", 96'(ack), 96'(0));
    check("cancel_idle", 96'(busy), 96'(0));

    for (int r = 0; r < 20; r++) begin
      m  = NC'($urandom_range(1, 15));
      lt = NC'($urandom_range(0, 15));
      for (int unsigned c = 0; c < NC; c++) begin
        if (m[c] || lt[c]) begin
          case ($urandom_range(0, 3))
            0:       set_val(c, 0);
            1:       set_val(c, MaxVal);
            default: set_val(c, $urandom_range(0, MaxVal));
          endcase
        end
      end
      run_batch(m, lt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
